// File: rtl/ltl_monitor_pkg.sv
// Shared definitions for the LTL automata monitor: default report/offset
// widths (also used by the automata instantiation wrapper), the capture
// record layout and small sizing helpers.
package ltl_monitor_pkg;

  localparam int N_REPORTS_DEF = 4;
  localparam int OFFSET_W_DEF  = 16;
  localparam int REC_W_DEF     = N_REPORTS_DEF + OFFSET_W_DEF;

  // One captured report: the report vector plus the index of the symbol that caused it.
  typedef struct packed {
    logic [N_REPORTS_DEF-1:0] report;
    logic [OFFSET_W_DEF-1:0]  offset;
  } report_rec_t;

  // Pointer width for a power-of-two FIFO: index bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ltl_report_fifo.sv
// First-word-fall-through FIFO for report records. The head entry is kept in
// a dedicated register, so valid and head data come straight from flops and
// a push into an empty FIFO becomes visible on the following cycle.
module ltl_report_fifo
  import ltl_monitor_pkg::*;
#(
  parameter int WIDTH = REC_W_DEF,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             push_s, pop_s;

  // Full when the index bits match but the wrap bits differ.
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = !valid_q;
  assign head_data = head_q;

  // Next pointers, storage and head register; the head is read from the post-write storage view.
  always_comb begin
    pop_s  = pop && valid_q;
    push_s = push && (!full || pop_s);
    mem_d  = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    valid_d = (wr_ptr_d != rd_ptr_d);
    if (valid_d) begin
      head_d = mem_d[rd_ptr_d[AW-1:0]];
    end else begin
      head_d = head_q;
    end
  end

  // Control and head registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  // Record storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ltl_report_collector.sv
// Capture stage for an LTL automata monitor: tags every non-zero report
// vector with the index of the symbol that produced it and queues it in a
// FWFT FIFO; records lost on a full FIFO raise overflow and are counted.
// Optional build macro MONITOR_REPORT_DEDUP_EN suppresses a qualified report
// that repeats the vector of the immediately preceding qualified cycle.
module ltl_report_collector
  import ltl_monitor_pkg::*;
#(
  parameter int N_REPORTS = N_REPORTS_DEF,
  parameter int OFFSET_W  = OFFSET_W_DEF,
  parameter int DEPTH     = 8,
  parameter int DROP_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [N_REPORTS-1:0] report_in,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [N_REPORTS-1:0] out_report,
  output logic [OFFSET_W-1:0]  out_offset,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_count
);

  localparam int REC_W = N_REPORTS + OFFSET_W;

  typedef struct packed {
    logic [N_REPORTS-1:0] report;
    logic [OFFSET_W-1:0]  offset;
  } rec_t;

  logic [OFFSET_W-1:0] sym_count_q, sym_count_d;
  logic                run_q, run_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_count_q, drop_count_d;
  logic                qual_s, suppress_s, push_req_s, push_s, pop_s, drop_s;
  logic                fifo_full_s, fifo_empty_s;
  rec_t                rec_s, head_s;
  logic [REC_W-1:0]    head_bits_s;

`ifdef MONITOR_REPORT_DEDUP_EN
  logic [N_REPORTS-1:0] hist_q, hist_d;

  // Remember the last qualified vector; any unqualified cycle breaks the run.
  always_comb begin
    if (qual_s) begin
      hist_d = report_in;
    end else begin
      hist_d = '0;
    end
    suppress_s = qual_s && (report_in == hist_q);
  end

  // History register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  assign suppress_s = 1'b0;
`endif

  // Qualification, record build and push/drop decision. Reports lag their symbol by one cycle.
  always_comb begin
    qual_s        = run_q && (report_in != '0);
    rec_s.report  = report_in;
    rec_s.offset  = sym_count_q - OFFSET_W'(1);
    push_req_s    = qual_s && !suppress_s && !reset;
    pop_s         = !fifo_empty_s && out_ready;
    push_s        = push_req_s && (!fifo_full_s || pop_s);
    drop_s        = push_req_s && !push_s;
  end

  // Symbol counter, run delay and drop accounting next state.
  always_comb begin
    run_d      = run;
    overflow_d = overflow_q || drop_s;
    if (run) begin
      sym_count_d = sym_count_q + OFFSET_W'(1);
    end else begin
      sym_count_d = sym_count_q;
    end
    if (drop_s && (drop_count_q != {DROP_W{1'b1}})) begin
      drop_count_d = drop_count_q + DROP_W'(1);
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // Collector state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_count_q  <= '0;
      run_q        <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      sym_count_q  <= sym_count_d;
      run_q        <= run_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  ltl_report_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (rec_s),
    .full      (fifo_full_s),
    .pop       (pop_s),
    .empty     (fifo_empty_s),
    .head_data (head_bits_s)
  );

  assign head_s     = head_bits_s;
  assign out_valid  = !fifo_empty_s;
  assign out_report = head_s.report;
  assign out_offset = head_s.offset;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule
